// File: rtl/window_buffer_pp_pkg.sv
// rtl/window_buffer_pp_pkg.sv - shared CNN constants and clog2 helper
package cnn_defs;

    localparam int DEF_DATA_W  = 8;
    localparam int DEF_IMG_DIM = 13;
    localparam int DEF_WIN     = 4;
    localparam int DEF_LANES   = 4;

    // Never returns 0 so every derived vector keeps at least one bit.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r++;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/window_buffer_pp_if.sv
// rtl/window_buffer_pp_if.sv - tile write stream, window read and status signals
interface window_buffer_pp_if
    import cnn_defs::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int IMG_DIM = DEF_IMG_DIM,
    parameter int WIN     = DEF_WIN,
    parameter int LANES   = DEF_LANES
);
    localparam int K_W = clog2(IMG_DIM);

    logic                      wr_en;
    logic [LANES*DATA_W-1:0]   wr_data;
    logic                      wr_ready;
    logic                      wr_drop;
    logic                      rd_avail;
    logic                      rd_req;
    logic [K_W-1:0]            k;
    logic [K_W-1:0]            q;
    logic                      rd_release;
    logic                      win_valid;
    logic                      win_err;
    logic [WIN*WIN*DATA_W-1:0] win_data;
    logic [1:0]                bank_full;

    modport master (
        output wr_en, wr_data, rd_req, k, q, rd_release,
        input  wr_ready, wr_drop, rd_avail, win_valid, win_err, win_data, bank_full
    );

    modport slave (
        input  wr_en, wr_data, rd_req, k, q, rd_release,
        output wr_ready, wr_drop, rd_avail, win_valid, win_err, win_data, bank_full
    );

endinterface

// File: rtl/window_buffer_pp_window_bank.sv
// rtl/window_buffer_pp_window_bank.sv - one tile bank: lane write port and WIN x WIN window mux
module window_bank
    import cnn_defs::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int IMG_DIM = DEF_IMG_DIM,
    parameter int WIN     = DEF_WIN,
    parameter int LANES   = DEF_LANES,
    parameter int CNT_W   = clog2(IMG_DIM*IMG_DIM + LANES),
    parameter int K_W     = clog2(IMG_DIM)
) (
    input  logic                      i_clk,
    input  logic                      i_we,
    input  logic [CNT_W-1:0]          i_base,
    input  logic [LANES-1:0]          i_mask,
    input  logic [LANES*DATA_W-1:0]   i_data,
    input  logic [K_W-1:0]            i_k,
    input  logic [K_W-1:0]            i_q,
    output logic [WIN*WIN*DATA_W-1:0] o_win
);
    localparam int NPIX  = IMG_DIM*IMG_DIM;
    localparam int IDX_W = clog2(NPIX);

    logic [DATA_W-1:0] r_mem [NPIX];

    // Pixel storage is deliberately not reset; bank_full gates every read.
    always_ff @(posedge i_clk) begin
        for (int l = 0; l < LANES; l++) begin
            if (i_we && i_mask[l]) begin
                r_mem[IDX_W'(int'(i_base) + l)] <= i_data[l*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        o_win = '0;
        for (int i = 0; i < WIN; i++) begin
            for (int j = 0; j < WIN; j++) begin
                o_win[(i*WIN+j)*DATA_W +: DATA_W] =
                    r_mem[IDX_W'((int'(i_k) + i)*IMG_DIM + int'(i_q) + j)];
            end
        end
    end

endmodule

// File: rtl/window_buffer_pp.sv
// rtl/window_buffer_pp.sv - ping-pong tile buffer: fills one bank while windows are read from the other
module window_buffer_pp
    import cnn_defs::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int IMG_DIM = DEF_IMG_DIM,
    parameter int WIN     = DEF_WIN,
    parameter int LANES   = DEF_LANES
) (
    input  logic               clk,
    input  logic               rst_n,
    window_buffer_pp_if.slave  bus
);
    localparam int NPIX  = IMG_DIM*IMG_DIM;
    localparam int CNT_W = clog2(NPIX + LANES);
    localparam int K_W   = clog2(IMG_DIM);
    localparam int WIN_W = WIN*WIN*DATA_W;

    logic [CNT_W-1:0] r_wr_cnt;
    logic             r_wr_bank;
    logic             r_rd_bank;
    logic [1:0]       r_bank_full;
    logic             r_win_valid;
    logic             r_win_err;
    logic             r_wr_drop;
    logic [WIN_W-1:0] r_win_data;

    logic             w_wr_ready;
    logic             w_rd_avail;
    logic             w_accept;
    logic             w_last;
    logic             w_release;
    logic             w_in_range;
    logic             w_rd_ok;
    logic [LANES-1:0] w_mask;
    logic [1:0]       w_bank_full_nxt;
    logic [WIN_W-1:0] w_win0;
    logic [WIN_W-1:0] w_win1;

    assign w_wr_ready = ~r_bank_full[r_wr_bank];
    assign w_rd_avail = r_bank_full[r_rd_bank];
    assign w_accept   = bus.wr_en & w_wr_ready;
    assign w_last     = (int'(r_wr_cnt) + LANES) >= NPIX;
    assign w_release  = bus.rd_release & w_rd_avail;
    assign w_in_range = (int'(bus.k) <= IMG_DIM - WIN) && (int'(bus.q) <= IMG_DIM - WIN);
    assign w_rd_ok    = bus.rd_req & w_rd_avail;

    // Lanes past the end of the tile are masked off, giving the partial last beat.
    always_comb begin
        w_mask = '0;
        for (int l = 0; l < LANES; l++) begin
            w_mask[l] = (int'(r_wr_cnt) + l) < NPIX;
        end
    end

    // Completion is applied after release so a same-bank race leaves the bank full.
    always_comb begin
        w_bank_full_nxt = r_bank_full;
        if (w_release) begin
            w_bank_full_nxt[r_rd_bank] = 1'b0;
        end
        if (w_accept && w_last) begin
            w_bank_full_nxt[r_wr_bank] = 1'b1;
        end
    end

    window_bank #(
        .DATA_W(DATA_W), .IMG_DIM(IMG_DIM), .WIN(WIN), .LANES(LANES), .CNT_W(CNT_W), .K_W(K_W)
    ) u_bank0 (
        .i_clk  (clk),
        .i_we   (w_accept & ~r_wr_bank),
        .i_base (r_wr_cnt),
        .i_mask (w_mask),
        .i_data (bus.wr_data),
        .i_k    (bus.k),
        .i_q    (bus.q),
        .o_win  (w_win0)
    );

    window_bank #(
        .DATA_W(DATA_W), .IMG_DIM(IMG_DIM), .WIN(WIN), .LANES(LANES), .CNT_W(CNT_W), .K_W(K_W)
    ) u_bank1 (
        .i_clk  (clk),
        .i_we   (w_accept & r_wr_bank),
        .i_base (r_wr_cnt),
        .i_mask (w_mask),
        .i_data (bus.wr_data),
        .i_k    (bus.k),
        .i_q    (bus.q),
        .o_win  (w_win1)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_cnt    <= '0;
            r_wr_bank   <= 1'b0;
            r_rd_bank   <= 1'b0;
            r_bank_full <= 2'b00;
            r_win_valid <= 1'b0;
            r_win_err   <= 1'b0;
            r_wr_drop   <= 1'b0;
            r_win_data  <= '0;
        end else begin
            r_bank_full <= w_bank_full_nxt;
            if (w_accept) begin
                if (w_last) begin
                    r_wr_cnt  <= '0;
                    r_wr_bank <= ~r_wr_bank;
                end else begin
                    r_wr_cnt  <= r_wr_cnt + CNT_W'(LANES);
                end
            end
            r_wr_drop   <= bus.wr_en & ~w_wr_ready;
            r_win_valid <= w_rd_ok & w_in_range;
            r_win_err   <= w_rd_ok & ~w_in_range;
            if (w_rd_ok && w_in_range) begin
                r_win_data <= r_rd_bank ? w_win1 : w_win0;
            end
            if (w_release) begin
                r_rd_bank <= ~r_rd_bank;
            end
        end
    end

    assign bus.wr_ready  = w_wr_ready;
    assign bus.wr_drop   = r_wr_drop;
    assign bus.rd_avail  = w_rd_avail;
    assign bus.win_valid = r_win_valid;
    assign bus.win_err   = r_win_err;
    assign bus.win_data  = r_win_data;
    assign bus.bank_full = r_bank_full;

endmodule

// File: tb/tb_window_buffer_pp.sv
// tb/tb_window_buffer_pp.sv - directed self-checking bench for window_buffer_pp
module tb_window_buffer_pp;
    import cnn_defs::*;

    localparam int DATA_W  = DEF_DATA_W;
    localparam int IMG_DIM = DEF_IMG_DIM;
    localparam int WIN     = DEF_WIN;
    localparam int LANES   = DEF_LANES;
    localparam int NPIX    = IMG_DIM*IMG_DIM;
    localparam int NBEATS  = (NPIX + LANES - 1) / LANES;
    localparam int WIN_W   = WIN*WIN*DATA_W;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;
    logic [WIN_W-1:0] held;

    window_buffer_pp_if #(.DATA_W(DATA_W), .IMG_DIM(IMG_DIM), .WIN(WIN), .LANES(LANES)) bus ();

    window_buffer_pp #(.DATA_W(DATA_W), .IMG_DIM(IMG_DIM), .WIN(WIN), .LANES(LANES)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [WIN_W-1:0] obs, input logic [WIN_W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [WIN_W-1:0] exp_win(input int kk, input int qq, input int off);
        logic [WIN_W-1:0] r;
        r = '0;
        for (int i = 0; i < WIN; i++) begin
            for (int j = 0; j < WIN; j++) begin
                r[(i*WIN+j)*DATA_W +: DATA_W] = DATA_W'(((kk+i)*IMG_DIM + qq + j + off) % 256);
            end
        end
        return r;
    endfunction

    task automatic beat(input int b, input int off);
        bus.wr_en = 1'b1;
        for (int l = 0; l < LANES; l++) begin
            bus.wr_data[l*DATA_W +: DATA_W] = DATA_W'((b*LANES + l + off) % 256);
        end
        tick();
        bus.wr_en = 1'b0;
    endtask

    task automatic read(input int kk, input int qq);
        bus.rd_req = 1'b1;
        bus.k      = 4'(kk);
        bus.q      = 4'(qq);
        tick();
        bus.rd_req = 1'b0;
    endtask

    initial begin
        n_checks       = 0;
        n_errors       = 0;
        rst_n          = 1'b0;
        bus.wr_en      = 1'b0;
        bus.wr_data    = '0;
        bus.rd_req     = 1'b0;
        bus.k          = '0;
        bus.q          = '0;
        bus.rd_release = 1'b0;
        tick();
        tick();
        chk("reset_bank_full", WIN_W'(bus.bank_full), WIN_W'(2'b00));
        chk("reset_wr_ready", WIN_W'(bus.wr_ready), WIN_W'(1));
        chk("reset_rd_avail", WIN_W'(bus.rd_avail), WIN_W'(0));
        chk("reset_win_valid", WIN_W'(bus.win_valid), WIN_W'(0));
        chk("reset_win_err", WIN_W'(bus.win_err), WIN_W'(0));
        chk("reset_wr_drop", WIN_W'(bus.wr_drop), WIN_W'(0));
        chk("reset_win_data", bus.win_data, '0);
        rst_n = 1'b1;
        tick();

        // Fill bank 0 with index%256
        for (int b = 0; b < NBEATS - 1; b++) beat(b, 0);
        chk("fill0_before_last", WIN_W'(bus.bank_full), WIN_W'(2'b00));
        beat(NBEATS - 1, 0);
        chk("fill0_bank_full", WIN_W'(bus.bank_full), WIN_W'(2'b01));
        chk("fill0_rd_avail", WIN_W'(bus.rd_avail), WIN_W'(1));
        chk("fill0_wr_ready", WIN_W'(bus.wr_ready), WIN_W'(1));

        read(0, 0);
        chk("win00_valid", WIN_W'(bus.win_valid), WIN_W'(1));
        chk("win00_elem00", WIN_W'(bus.win_data[7:0]), WIN_W'(8'h00));
        chk("win00_full", bus.win_data, exp_win(0, 0, 0));
        tick();
        chk("win00_valid_pulse", WIN_W'(bus.win_valid), WIN_W'(0));
        read(9, 9);
        chk("win99_valid", WIN_W'(bus.win_valid), WIN_W'(1));
        chk("win99_elem33", WIN_W'(bus.win_data[127:120]), WIN_W'(168));
        chk("win99_full", bus.win_data, exp_win(9, 9, 0));
        held = bus.win_data;

        read(10, 0);
        chk("range_k_err", WIN_W'(bus.win_err), WIN_W'(1));
        chk("range_k_valid", WIN_W'(bus.win_valid), WIN_W'(0));
        chk("range_k_data_held", bus.win_data, held);
        read(0, 10);
        chk("range_q_err", WIN_W'(bus.win_err), WIN_W'(1));
        tick();
        chk("range_err_pulse", WIN_W'(bus.win_err), WIN_W'(0));

        // Fill bank 1 with index+100
        for (int b = 0; b < NBEATS; b++) beat(b, 100);
        chk("fill1_bank_full", WIN_W'(bus.bank_full), WIN_W'(2'b11));
        chk("fill1_wr_ready", WIN_W'(bus.wr_ready), WIN_W'(0));
        beat(0, 200);
        chk("drop_pulse", WIN_W'(bus.wr_drop), WIN_W'(1));
        chk("drop_no_change", WIN_W'(bus.bank_full), WIN_W'(2'b11));
        tick();
        chk("drop_clear", WIN_W'(bus.wr_drop), WIN_W'(0));

        // Read and release in the same cycle: window comes from bank 0
        bus.rd_release = 1'b1;
        read(2, 3);
        bus.rd_release = 1'b0;
        chk("simul_valid", WIN_W'(bus.win_valid), WIN_W'(1));
        chk("simul_elem00", WIN_W'(bus.win_data[7:0]), WIN_W'(29));
        chk("simul_full", bus.win_data, exp_win(2, 3, 0));
        chk("simul_bank_full", WIN_W'(bus.bank_full), WIN_W'(2'b10));
        chk("simul_rd_avail", WIN_W'(bus.rd_avail), WIN_W'(1));
        chk("simul_wr_ready", WIN_W'(bus.wr_ready), WIN_W'(1));
        read(0, 0);
        chk("bank1_elem00", WIN_W'(bus.win_data[7:0]), WIN_W'(100));

        // Back-to-back reads
        bus.rd_req = 1'b1;
        bus.k = 4'd1; bus.q = 4'd2;
        tick();
        chk("b2b_first", bus.win_data, exp_win(1, 2, 100));
        bus.k = 4'd8; bus.q = 4'd5;
        tick();
        bus.rd_req = 1'b0;
        chk("b2b_second_valid", WIN_W'(bus.win_valid), WIN_W'(1));
        chk("b2b_second", bus.win_data, exp_win(8, 5, 100));

        bus.rd_release = 1'b1;
        tick();
        bus.rd_release = 1'b0;
        chk("release1_rd_avail", WIN_W'(bus.rd_avail), WIN_W'(0));
        held = bus.win_data;
        read(0, 0);
        chk("empty_req_valid", WIN_W'(bus.win_valid), WIN_W'(0));
        chk("empty_req_err", WIN_W'(bus.win_err), WIN_W'(0));
        chk("empty_req_data", bus.win_data, held);

        // Asynchronous reset in the middle of a fill
        for (int b = 0; b < 20; b++) beat(b, 7);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_win_data", bus.win_data, '0);
        chk("async_bank_full", WIN_W'(bus.bank_full), WIN_W'(2'b00));
        chk("async_wr_ready", WIN_W'(bus.wr_ready), WIN_W'(1));
        tick();
        rst_n = 1'b1;
        tick();
        for (int b = 0; b < NBEATS; b++) beat(b, 50);
        chk("refill_bank_full", WIN_W'(bus.bank_full), WIN_W'(2'b01));
        read(5, 7);
        chk("refill_valid", WIN_W'(bus.win_valid), WIN_W'(1));
        chk("refill_win", bus.win_data, exp_win(5, 7, 50));
        read(0, 0);
        chk("refill_win00", bus.win_data, exp_win(0, 0, 50));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/window_buffer_pp.md
Name: window_buffer_pp

Overview:
Parametrised, double-buffered (ping-pong) image tile buffer for the CNN datapath. The write side streams LANES pixels per beat into one bank. The read side extracts WIN x WIN windows at arbitrary (k,q) offsets from the other, completely filled bank. Sits between the input/feature-map memory reader and the convolution engine, so that loading tile N+1 overlaps computation on tile N.

Parameters:
DATA_W, 8, pixel width in bits
IMG_DIM, 13, tile side length (tile holds IMG_DIM*IMG_DIM pixels)
WIN, 4, window side length (WIN <= IMG_DIM)
LANES, 4, pixels written per write beat (1..IMG_DIM)

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
wr_en  in  1  write beat request
wr_data  in  LANES*DATA_W  pixels; lane l at bits [l*DATA_W +: DATA_W], lane 0 = lowest linear index
wr_ready  out  1  current write bank is accepting data
wr_drop  out  1  one-cycle pulse: wr_en seen while wr_ready=0
rd_avail  out  1  current read bank holds a complete tile
rd_req  in  1  window read request
k  in  clog2(IMG_DIM)  window top row
q  in  clog2(IMG_DIM)  window left column
rd_release  in  1  consumer finished with current read bank
win_valid  out  1  one-cycle pulse: win_data holds the requested window
win_err  out  1  one-cycle pulse: request was out of range
win_data  out  WIN*WIN*DATA_W  element (i,j) = pixel[k+i][q+j] at bits [(i*WIN+j)*DATA_W +: DATA_W]
bank_full  out  2  per-bank full flags (status/debug)

Behaviour:
- Reset (async, rst_n=0): bank_full=0, wr_bank=0, rd_bank=0, wr_cnt=0, win_valid=0, win_err=0, wr_drop=0, win_data=0. Pixel storage is not reset. Deassertion takes effect on the next clk edge.
- Pixel linear index n maps to row n/IMG_DIM, column n%IMG_DIM. wr_cnt is the index of lane 0; width clog2(IMG_DIM*IMG_DIM+LANES).
- wr_ready = ~bank_full[wr_bank]. wr_ready and rd_avail are combinational from registered state.
- Accepted beat (wr_en & wr_ready): lane l is written to index wr_cnt+l. Lanes with index >= IMG_DIM*IMG_DIM are discarded, which gives a partial last beat (defaults: 43 beats, last beat lane 0 only).
  - If wr_cnt+LANES >= IMG_DIM*IMG_DIM: set bank_full[wr_bank], wr_cnt <= 0, toggle wr_bank.
  - Otherwise: wr_cnt <= wr_cnt+LANES.
- wr_en & ~wr_ready: no write, no state change; wr_drop=1 on the next cycle.
- rd_avail = bank_full[rd_bank].
- rd_req & rd_avail, with k <= IMG_DIM-WIN and q <= IMG_DIM-WIN: win_data is registered from bank rd_bank; win_valid=1 for exactly the following cycle. Latency is 1. win_data holds its value until the next valid read.
- rd_req & rd_avail with k or q out of range: win_data unchanged, win_valid=0, win_err=1 on the following cycle.
- rd_req & ~rd_avail: ignored. No valid, no error.
- rd_release & rd_avail: clear bank_full[rd_bank], toggle rd_bank. rd_release & ~rd_avail is ignored.
- rd_req and rd_release in the same cycle: the read uses the pre-release bank, then the release takes effect. Back-to-back rd_req is supported at full rate (one window per cycle).
- Write completion and release in the same cycle act on different banks and are independent. If both target the same bank index (a single-bank race), completion sets the flag and release is evaluated first, so the bank ends full.
- Data ordering: banks fill and drain strictly alternately (0,1,0,...). A bank never serves reads until its final beat is accepted.
- Reset mid-fill or mid-read: all progress is abandoned, the next write starts at bank 0 index 0, and no win_valid is issued for requests in flight.

Decomposition:
- Shared CNN constants package (cnn_defs): default DATA_W, IMG_DIM, WIN, LANES, and a clog2 helper function.
- One sub-module, window_bank, instantiated twice:
  - IMG_DIM x IMG_DIM storage
  - LANES-wide write port taking (we, base index, lane mask)
  - combinational WIN x WIN window mux at (k,q)
- The top level holds pointers, flags, wr_cnt and the output registers.

Test Plan:
- Fill: reset, 43 beats with pixel value = index%256 -> bank_full=01 after beat 43 and rd_avail=1; wr_ready stays 1 (bank 1 empty); beat 43 lanes 1-3 are discarded.
- Window read: rd_req at k=0,q=0 then k=9,q=9 -> win_valid one cycle after each; element(0,0)=0x00 for the first window and element(3,3)=pixel[12][12]=168 for the second.
- Range check: k=10,q=0 -> win_err pulse, win_valid=0, win_data unchanged.
- Ping-pong: fill both banks (second with index+100) -> wr_ready=0; an extra wr_en pulses wr_drop. rd_release -> rd_bank=1; k=0,q=0 reads 100. wr_ready=1 again for bank 0.
- Simultaneous: rd_req (k=2,q=3) and rd_release in the same cycle -> window from the old bank (element(0,0)=29), then rd_avail reflects the other bank.
- Async reset asserted mid-fill (after 20 beats) and between clocks -> outputs clear immediately; a refill of 43 beats yields correct windows.
